if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the pipelined MIPS32 core. It sits directly upstream of the ID stage and feeds the main decoder. It owns the PC and the IF/ID pipeline register, and reads instruction memory. It obeys stall and redirect requests from later stages, and pre-decodes HLT so fetch stops cleanly while the pipeline drains.

## Interface
Parameters:
- ADDR_W, 32, PC / instruction-address width (byte address)
- RESET_PC, 0, PC value loaded on reset (low two bits must be 0)

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  sole clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- imem_addr  out  ADDR_W  instruction memory address; always equals current PC
- imem_rdata  in  32  instruction word, combinational read of imem_addr in the same cycle
- stall  in  1  hazard unit: hold PC, IF/ID, state and counter
- redirect  in  1  taken branch / J / JR resolved downstream
- redirect_pc  in  ADDR_W  redirect target
- ifid_valid  out  1  IF/ID holds a real instruction; ID gates all control with it
- ifid_instr  out  32  fetched instruction to decoder
- ifid_pc4  out  ADDR_W  address of the fetched instruction + 4
- halted  out  1  fetch stopped after an HLT
- fetch_count  out  32  count of instructions loaded into IF/ID

## Operation
- States: RUN, HALTED.
- Per-cycle priority: reset > redirect > stall > normal.
- Reset: pc=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc4=0, state=RUN, halted=0, fetch_count=0.
- Redirect (any state, stall ignored): pc<=redirect_pc with bits [1:0] forced to 0; ifid_valid<=0 (flush); ifid_instr<=0; state<=RUN. fetch_count is unchanged.
- Stall with no redirect: pc, IF/ID, state and fetch_count all hold.
- RUN, normal, opcode imem_rdata[31:26] != 6'b111111:
  - IF/ID<={1, imem_rdata, pc+4}; pc<=pc+4; fetch_count++.
- RUN, normal, opcode == HLT (6'b111111):
  - IF/ID<={1, imem_rdata, pc+4}; fetch_count++.
  - pc holds at the HLT address; state<=HALTED.
- HALTED, normal: ifid_valid<=0 (bubble every cycle), ifid_instr<=0; pc holds; fetch_count holds.
- HALTED exits only via redirect or reset.
- halted = (state==HALTED), registered.
- PC arithmetic is modulo 2^ADDR_W; pc+4 wraps silently.
- fetch_count wraps modulo 2^32.

## Timing
- Fetch latency: 1 cycle. The instruction at imem_addr during cycle N appears on ifid_* after edge N.
- First valid instruction (RESET_PC) is on ifid_* one cycle after the first cycle with rst_n=1.
- Redirect asserted in cycle N:
  - ifid_valid=0 after edge N.
  - imem_addr=redirect_pc in cycle N+1.
  - Target instruction is valid after edge N+1.
- Redirect and HLT fetched in the same cycle: redirect wins; no halt, the HLT is dropped (wrong path).
- Redirect while HLT sits in IF/ID or state is HALTED: flush and resume; halted=0 after that edge.
- Stall while HLT is on imem_rdata in RUN: no transition; HLT is re-evaluated when the stall drops.
- Stall in HALTED: IF/ID keeps its content (the HLT may still be present); no bubble is inserted.
- Reset mid-operation: all state returns to reset values on that edge regardless of stall or redirect.

## Structure
- Shared package mips_isa_pkg holds:
  - opcode constants, including HLT_OP=6'b111111, common with the main decoder
  - NOP_INSTR=32'h0
  - the fetch state enum {RUN, HALTED}
- One natural sub-module: if_pc_gen.
  - Contains the PC register, next-PC mux (redirect / +4 / hold) and alignment masking.
  - if_stage adds the IF/ID register, the halt FSM and fetch_count.

## Test plan
- Reset then free run, RESET_PC=0, imem holds ADDs:
  - ifid_pc4 = 4, 8, 12 on consecutive cycles; ifid_valid=1 from the first cycle after reset; fetch_count = 1, 2, 3.
- stall high for 3 cycles at pc=0x10: imem_addr stays 0x10; ifid_* and fetch_count frozen; resumes at 0x14 after stall drops.
- redirect=1, redirect_pc=0x43 with stall=1:
  - next cycle: ifid_valid=0 and imem_addr=0x40.
  - following cycle: instruction from 0x40 valid with ifid_pc4=0x44.
- HLT at 0x20:
  - HLT enters IF/ID with ifid_valid=1.
  - then ifid_valid=0 for all later cycles, halted=1, imem_addr=0x20, fetch_count frozen.
  - a later redirect to 0x100 clears halted and fetches from 0x100.
- HLT on imem_rdata in the same cycle as redirect to 0x80: halted stays 0; next valid instruction comes from 0x80.
- PC wrap: RESET_PC=0xFFFFFFFC gives ifid_pc4=0x0, then imem_addr=0x0. rst_n low mid-run returns all outputs to reset values next edge.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared MIPS32 ISA definitions: opcodes, the canonical NOP and the fetch-state
// encoding used by the IF stage and the main decoder.
package mips_isa_pkg;

  localparam logic [5:0] RTYPE_OP = 6'b000000;
  localparam logic [5:0] J_OP     = 6'b000010;
  localparam logic [5:0] JAL_OP   = 6'b000011;
  localparam logic [5:0] BEQ_OP   = 6'b000100;
  localparam logic [5:0] BNE_OP   = 6'b000101;
  localparam logic [5:0] ADDI_OP  = 6'b001000;
  localparam logic [5:0] LW_OP    = 6'b100011;
  localparam logic [5:0] SW_OP    = 6'b101011;
  localparam logic [5:0] HLT_OP   = 6'b111111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  function automatic logic is_hlt(input logic [31:0] instr);
    return instr[31:26] == HLT_OP;
  endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Program counter with next-PC selection (redirect / +4 / hold); all addresses
// leaving this block are word aligned.
module if_pc_gen #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              advance,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  assign pc_plus4 = pc + ADDR_W'(4);

  // Redirect overrides any stall or halt hold coming in through advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC & ALIGN_MASK;
    end else if (redirect) begin
      pc <= redirect_pc & ALIGN_MASK;
    end else if (advance) begin
      pc <= pc_plus4;
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS32 instruction-fetch stage: PC, IF/ID register, HLT pre-decode with a
// RUN/HALTED fetch FSM, and a count of instructions delivered to ID.
module if_stage
  import mips_isa_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ifid_valid,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              fetch_hlt;
  logic              advance;

  assign fetch_hlt = is_hlt(imem_rdata);
  // PC moves only on a normal RUN fetch of a non-HLT; HLT parks the PC on itself.
  assign advance   = !stall && (state == RUN) && !fetch_hlt;
  assign imem_addr = pc;
  assign halted    = (state == HALTED);

  if_pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .advance     (advance),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  // IF/ID register, fetch FSM and counter; ifid_pc4 is left as-is on flush/bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      ifid_valid  <= 1'b0;
      ifid_instr  <= NOP_INSTR;
      ifid_pc4    <= '0;
      fetch_count <= '0;
    end else if (redirect) begin
      state      <= RUN;
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end else if (!stall) begin
      case (state)
        RUN: begin
          ifid_valid  <= 1'b1;
          ifid_instr  <= imem_rdata;
          ifid_pc4    <= pc_plus4;
          fetch_count <= fetch_count + 32'd1;
          if (fetch_hlt) state <= HALTED;
        end
        HALTED: begin
          ifid_valid <= 1'b0;
          ifid_instr <= NOP_INSTR;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
